mega_ram_arbiter: RTL and testbench
===================================

// Module: mega_ram_arbiter
//
// PURPOSE
//   Shares one single-port mega RAM (1-cycle registered read, output gated by re)
//   between the CPU data port and a burst-read DMA port (e.g. display framebuffer fetch).
//   CPU has fixed priority; DMA bursts fill idle RAM cycles with sequential reads.
//   Sits between the CPU/DMA masters and the RAM instance; drives all RAM pins.
//
// PARAMETERS
//   ADDR_BUS_WIDTH  13  RAM address width; addresses wrap modulo 2**ADDR_BUS_WIDTH
//   DATA_BUS_WIDTH  8   RAM data width
//   LEN_W           8   DMA length field width; burst = dma_len+1 beats (1..2**LEN_W)
//   STARVE_LIMIT    8   fairness only: consecutive denied DMA cycles before forced grant
//
// PORTS
//   clk          in   1    system clock, all logic on rising edge
//   rst          in   1    synchronous, active-high reset
//   cpu_we       in   1    CPU write strobe (this cycle)
//   cpu_re       in   1    CPU read strobe (this cycle)
//   cpu_a        in   AW   CPU address
//   cpu_d_in     in   DW   CPU write data
//   cpu_d_out    out  DW   CPU read data, valid cycle after accepted read, else 0
//   cpu_stall    out  1    CPU access not accepted this cycle; CPU holds request
//   dma_start    in   1    1-cycle pulse: begin burst at dma_addr, dma_len
//   dma_addr     in   AW   burst start address (sampled with dma_start)
//   dma_len      in   LEN_W  beats minus one (sampled with dma_start)
//   dma_busy     out  1    burst in progress (start accepted, done not yet pulsed)
//   dma_rvalid   out  1    dma_rdata valid this cycle (one beat)
//   dma_rdata    out  DW   burst read data, in address order
//   dma_done     out  1    1-cycle pulse in the cycle after the last dma_rvalid
//   ram_we       out  1    to RAM we
//   ram_re       out  1    to RAM re (output gate, asserted in data-return cycle)
//   ram_a        out  AW   to RAM address
//   ram_d_in     out  DW   to RAM write data
//   ram_d_out    in   DW   from RAM read data
//
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; beat/starve counters 0; pending issue flags 0.
//   - States: IDLE -> (dma_start) BURST -> (last beat issued) DRAIN -> (last data) IDLE.
//     dma_start in BURST/DRAIN ignored; dma_busy=1 in BURST and DRAIN.
//   - Per cycle grant: CPU access (cpu_we|cpu_re) wins; else in BURST, one DMA beat issues.
//   - CPU issue: ram_a=cpu_a, ram_we=cpu_we, ram_d_in=cpu_d_in, combinational, 0 added latency.
//     cpu_we&cpu_re same cycle: write performed, read returns pre-write data.
//   - Read return: registered flags cpu_rd_q/dma_rd_q; ram_re=cpu_rd_q|dma_rd_q.
//     cpu_d_out=ram_d_out when cpu_rd_q else 0; dma_rvalid=dma_rd_q, dma_rdata=ram_d_out
//     when dma_rd_q else 0. Never both flags set.
//   - Latency: dma_start sampled at edge t -> first beat issues in cycle t+1 ->
//     first dma_rvalid in cycle t+2. Uncontended burst: rvalid on consecutive cycles.
//   - Beat address = start + beat index, incremented only on issued beats, wraps to 0
//     after 2**AW-1. CPU win defers the beat; address and count held, no beat lost/duplicated.
//   - Last beat issued when remaining count==0 -> DRAIN; dma_done pulses cycle after
//     its rvalid; dma_busy drops with dma_done. dma_len=0 gives a single beat.
//   - ram_we never asserted for DMA; idle cycles drive ram_we=0, ram_a=0.
//   - rst mid-burst: burst aborted, no dma_done, no further rvalid, state IDLE.
//
// CONFIGURATION
//   MEGA_RAM_ARB_FAIRNESS_EN defined: starve counter counts cycles in BURST where a beat
//     was denied; at STARVE_LIMIT the next cycle forces a DMA beat, cpu_stall=1 that cycle
//     (CPU access not issued, CPU holds it), counter clears on any issued beat.
//   Not defined: strict CPU priority, cpu_stall tied 0, DMA may starve indefinitely.
//
// TESTING
//   1. Assert rst 2 cycles mid-traffic -> all outputs 0, dma_busy=0, next start works.
//   2. CPU write 0xA5 @0x0010, then read @0x0010 -> cpu_d_out=0xA5 next cycle, 0 after.
//   3. RAM 0x100..0x103=00,11,22,33; dma_start addr 0x100 len 3 at t -> rvalid t+2..t+5
//      with 00,11,22,33; dma_done at t+6; dma_busy 1 from t+1 through t+6.
//   4. Same burst, CPU reads in cycles t+2,t+3 -> CPU data correct, DMA data still
//      00,11,22,33 in order, last rvalid at t+7, dma_done t+8.
//   5. dma_addr 0x1FFE len 3 (AW=13) -> beats read 0x1FFE,0x1FFF,0x0000,0x0001.
//   6. FAIRNESS_EN, STARVE_LIMIT=4, CPU reads every cycle, len 1 -> after 4 denied cycles
//      cpu_stall=1 one cycle, one beat issues, repeats; without macro: no rvalid, stall 0.

Source files
------------

// File: rtl/mega_ram_arbiter.sv
// rtl/mega_ram_arbiter.sv - CPU/DMA arbiter for one single-port RAM with 1-cycle registered read
// Optional DMA starvation guard enabled by defining MEGA_RAM_ARB_FAIRNESS_EN.
module mega_ram_arbiter #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int LEN_W          = 8,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
  output logic                      cpu_stall,
  input  logic                      dma_start,
  input  logic [ADDR_BUS_WIDTH-1:0] dma_addr,
  input  logic [LEN_W-1:0]          dma_len,
  output logic                      dma_busy,
  output logic                      dma_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] dma_rdata,
  output logic                      dma_done,
  output logic                      ram_we,
  output logic                      ram_re,
  output logic [ADDR_BUS_WIDTH-1:0] ram_a,
  output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
  input  logic [DATA_BUS_WIDTH-1:0] ram_d_out
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_BUS_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]          r_cnt;
  logic                      r_cpu_rd_q;
  logic                      r_dma_rd_q;
  logic                      r_done;

  logic w_cpu_req;
  logic w_in_burst;
  logic w_force;
  logic w_cpu_grant;
  logic w_dma_issue;

  // Grants are suppressed while rst is high so every output reads 0 during reset.
  assign w_cpu_req   = (cpu_we | cpu_re) & ~rst;
  assign w_in_burst  = (r_state == S_BURST) & ~rst;
  assign w_cpu_grant = w_cpu_req & ~w_force;
  assign w_dma_issue = w_in_burst & ~w_cpu_grant;

`ifdef MEGA_RAM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_in_burst || w_dma_issue) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_force = w_in_burst & (r_starve == SW'(STARVE_LIMIT));
`else
  assign w_force = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (dma_start) w_next = S_BURST;
      S_BURST: if (w_dma_issue && (r_cnt == '0)) w_next = S_DRAIN;
      S_DRAIN: if (r_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_cpu_rd_q <= 1'b0;
      r_dma_rd_q <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cpu_rd_q <= w_cpu_grant & cpu_re;
      r_dma_rd_q <= w_dma_issue;
      // DRAIN lasts two cycles: last rvalid, then the done pulse.
      r_done     <= (r_state == S_DRAIN) & ~r_done;
      if ((r_state == S_IDLE) && dma_start) begin
        r_addr <= dma_addr;
        r_cnt  <= dma_len;
      end else if (w_dma_issue) begin
        r_addr <= r_addr + ADDR_BUS_WIDTH'(1);
        if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign cpu_stall  = w_cpu_req & w_force;
  assign ram_we     = w_cpu_grant & cpu_we;
  assign ram_a      = w_cpu_grant ? cpu_a : (w_dma_issue ? r_addr : '0);
  assign ram_d_in   = w_cpu_grant ? cpu_d_in : '0;
  assign ram_re     = r_cpu_rd_q | r_dma_rd_q;
  assign cpu_d_out  = r_cpu_rd_q ? ram_d_out : '0;
  assign dma_rvalid = r_dma_rd_q;
  assign dma_rdata  = r_dma_rd_q ? ram_d_out : '0;
  assign dma_done   = r_done;
  assign dma_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mega_ram_arbiter.sv
// tb/tb_mega_ram_arbiter.sv - scoreboard bench for mega_ram_arbiter with a behavioural RAM
module tb_mega_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_we, cpu_re;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in, cpu_d_out;
  logic          cpu_stall;
  logic          dma_start;
  logic [AW-1:0] dma_addr;
  logic [LW-1:0] dma_len;
  logic          dma_busy, dma_rvalid, dma_done;
  logic [DW-1:0] dma_rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d_in, ram_d_out;

  mega_ram_arbiter #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .LEN_W(LW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_a(cpu_a), .cpu_d_in(cpu_d_in),
    .cpu_d_out(cpu_d_out), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .ram_we(ram_we), .ram_re(ram_re), .ram_a(ram_a), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read of pre-write data, output gated by re.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d_in;
    ram_q <= mem[ram_a];
  end
  assign ram_d_out = ram_re ? ram_q : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];
  int   doneq[$];
  int   stallq[$];
  int   checks = 0;
  int   errors = 0;
  bit   fair_en;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_c(int c, logic [DW-1:0] d);
    exp_t e;
    e.c = c; e.d = d;
    cq.push_back(e);
  endtask

  task automatic push_d(int c, logic [DW-1:0] d);
    exp_t e;
    e.c = c; e.d = d;
    dq.push_back(e);
  endtask

  // Monitor: each mid-cycle, outputs must match the queued expectation for this cycle, else idle 0.
  logic [DW-1:0] m_cpu, m_dma;
  logic          m_rv, m_done, m_stall;
  always @(negedge clk) begin
    while (cq.size() > 0 && cq[0].c < cyc) begin checks++; errors++; $display("FAIL cpu_missed at %0d", cq[0].c); void'(cq.pop_front()); end
    while (dq.size() > 0 && dq[0].c < cyc) begin checks++; errors++; $display("FAIL dma_missed at %0d", dq[0].c); void'(dq.pop_front()); end
    while (doneq.size() > 0 && doneq[0] < cyc) void'(doneq.pop_front());
    while (stallq.size() > 0 && stallq[0] < cyc) void'(stallq.pop_front());
    m_cpu = '0; m_dma = '0; m_rv = 1'b0;
    if (cq.size() > 0 && cq[0].c == cyc) m_cpu = cq.pop_front().d;
    if (dq.size() > 0 && dq[0].c == cyc) begin m_rv = 1'b1; m_dma = dq.pop_front().d; end
    m_done  = (doneq.size() > 0 && doneq[0] == cyc);
    m_stall = (stallq.size() > 0 && stallq[0] == cyc);
    chk("cpu_d_out", 32'(cpu_d_out), 32'(m_cpu));
    chk("dma_rvalid_rdata", {23'd0, dma_rvalid, dma_rdata}, {23'd0, m_rv, m_dma});
    chk("dma_done", 32'(dma_done), 32'(m_done));
    chk("cpu_stall", 32'(cpu_stall), 32'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(logic [AW-1:0] a, logic [DW-1:0] d);
    cpu_we = 1'b1; cpu_a = a; cpu_d_in = d;
    tick();
    cpu_we = 1'b0; cpu_a = '0; cpu_d_in = '0;
  endtask

  task automatic start(logic [AW-1:0] a, logic [LW-1:0] l);
    dma_start = 1'b1; dma_addr = a; dma_len = l;
    tick();
    dma_start = 1'b0; dma_addr = '0; dma_len = '0;
  endtask

  task automatic chk_all_zero(string name);
    chk({name, "_flags"}, {26'd0, dma_busy, dma_rvalid, dma_done, ram_we, ram_re, cpu_stall}, 32'd0);
    chk({name, "_buses"}, {3'd0, ram_a, ram_d_in, dma_rdata}, 32'd0);
  endtask

  int t;

  initial begin
`ifdef MEGA_RAM_ARB_FAIRNESS_EN
    fair_en = 1'b1;
`else
    fair_en = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b1; cpu_we = 0; cpu_re = 0; cpu_a = '0; cpu_d_in = '0;
    dma_start = 0; dma_addr = '0; dma_len = '0;
    tick(); tick();
    chk_all_zero("reset_state");
    rst = 1'b0;
    tick();

    // Preload burst data through the CPU port.
    cpu_write(13'h0100, 8'h00); cpu_write(13'h0101, 8'h11);
    cpu_write(13'h0102, 8'h22); cpu_write(13'h0103, 8'h33);
    cpu_write(13'h1FFE, 8'hE0); cpu_write(13'h1FFF, 8'hE1);
    cpu_write(13'h0000, 8'hF0); cpu_write(13'h0001, 8'hF1);

    // CPU write then read-back.
    cpu_write(13'h0010, 8'hA5);
    cpu_re = 1'b1; cpu_a = 13'h0010; push_c(cyc + 1, 8'hA5);
    tick();
    cpu_re = 1'b0; cpu_a = '0;
    tick(); tick();

    // Reset two cycles in the middle of a burst.
    t = cyc;
    push_d(t + 2, 8'h00); push_d(t + 3, 8'h11);
    start(13'h0100, 8'd3);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    chk("busy_after_reset", 32'(dma_busy), 32'd0);
    tick(); tick(); tick();

    // Uncontended burst: busy window t+1..t+6.
    t = cyc;
    push_d(t + 2, 8'h00); push_d(t + 3, 8'h11); push_d(t + 4, 8'h22); push_d(t + 5, 8'h33);
    doneq.push_back(t + 6);
    chk("busy_before_start", 32'(dma_busy), 32'd0);
    start(13'h0100, 8'd3);
    for (int i = 1; i <= 6; i++) begin
      chk("busy_in_burst", 32'(dma_busy), 32'd1);
      tick();
    end
    chk("busy_after_done", 32'(dma_busy), 32'd0);
    tick(); tick();

    // Burst with CPU reads in t+2 and t+3 deferring beats.
    t = cyc;
    push_d(t + 2, 8'h00); push_d(t + 5, 8'h11); push_d(t + 6, 8'h22); push_d(t + 7, 8'h33);
    doneq.push_back(t + 8);
    start(13'h0100, 8'd3);
    tick();
    cpu_re = 1'b1; cpu_a = 13'h0010; push_c(cyc + 1, 8'hA5);
    tick();
    cpu_a = 13'h0103; push_c(cyc + 1, 8'h33);
    tick();
    cpu_re = 1'b0; cpu_a = '0;
    for (int i = 0; i < 7; i++) tick();

    // Address wrap at the top of the RAM.
    t = cyc;
    push_d(t + 2, 8'hE0); push_d(t + 3, 8'hE1); push_d(t + 4, 8'hF0); push_d(t + 5, 8'hF1);
    doneq.push_back(t + 6);
    start(13'h1FFE, 8'd3);
    for (int i = 0; i < 8; i++) tick();

    // Single-beat burst.
    t = cyc;
    push_d(t + 2, 8'h22);
    doneq.push_back(t + 3);
    start(13'h0102, 8'd0);
    for (int i = 0; i < 5; i++) tick();

    // CPU reads every cycle for 12 cycles during a 2-beat burst.
    t = cyc;
    if (fair_en) begin
      push_d(t + 6, 8'h00); push_d(t + 11, 8'h11);
      doneq.push_back(t + 12);
    end else begin
      push_d(t + 14, 8'h00); push_d(t + 15, 8'h11);
      doneq.push_back(t + 16);
    end
    start(13'h0100, 8'd1);
    for (int k = 1; k <= 12; k++) begin
      cpu_re = 1'b1; cpu_a = 13'h0010;
      if (fair_en && (k == 5 || k == 10)) stallq.push_back(cyc);
      else push_c(cyc + 1, 8'hA5);
      tick();
    end
    cpu_re = 1'b0; cpu_a = '0;
    for (int i = 0; i < 8; i++) tick();

    chk("leftover_expectations", 32'(cq.size() + dq.size() + doneq.size() + stallq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
